// File: rtl/temp_sampler_pkg.sv
// Shared types and constants for the temperature SPI sampler.
//   state_t   : acquisition FSM states
//   WORD_W    : sensor word width
//   BIT_CNT_W : width of the SPI bit counter
//   acc_width : accumulator width for a 2^avg_log2 sample block
package temp_sampler_pkg;

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned BIT_CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT     = 3'd1,
        S_CS_SETUP = 3'd2,
        S_SHIFT    = 3'd3,
        S_CS_HOLD  = 3'd4,
        S_UPDATE   = 3'd5
    } state_t;

    // Enough headroom to sum 2^avg_log2 signed words without overflow.
    function automatic int unsigned acc_width(input int unsigned avg_log2);
        return WORD_W + avg_log2;
    endfunction

endpackage

// File: rtl/temp_spi_rx.sv
// SPI mode-0 receive engine: SCLK divider, bit counter and shift register.
//   clk, rst  : system clock, asynchronous active-high reset
//   start     : one-cycle pulse, begins a 16-bit transfer with a low half
//   spi_miso  : serial data, sampled on each SCLK rising edge, MSB first
//   spi_sclk  : SPI clock, idle low
//   done      : high in the last cycle of the final SCLK high half
//   word      : received word, complete and stable while done is high
module temp_spi_rx
    import temp_sampler_pkg::*;
#(
    parameter int unsigned CLK_DIV = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              spi_miso,
    output logic              spi_sclk,
    output logic              done,
    output logic [WORD_W-1:0] word
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    logic                 active;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 half_end;

    assign half_end = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    // Combinational so the caller can leave SHIFT on the same edge SCLK falls.
    assign done     = half_end && spi_sclk && (bit_cnt == BIT_CNT_W'(WORD_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            spi_sclk <= 1'b0;
            word     <= '0;
        end else if (start) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            spi_sclk <= 1'b0;
        end else if (active) begin
            if (half_end) begin
                div_cnt <= '0;
                if (!spi_sclk) begin
                    spi_sclk <= 1'b1;
                    word     <= {word[WORD_W-2:0], spi_miso};
                end else begin
                    spi_sclk <= 1'b0;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (done) begin
                        active <= 1'b0;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/temp_spi_sampler.sv
// Periodic SPI temperature acquisition with block averaging and alarm.
//   ACLK, ARESET : system clock, asynchronous active-high reset
//   enable       : run periodic conversions (a started frame always completes)
//   threshold    : signed alarm threshold, compared against temp_avg
//   alarm_clr    : one-cycle pulse clearing alarm (a simultaneous set wins)
//   spi_miso     : sensor data in
//   spi_sclk     : SPI clock, idle low
//   spi_cs_n     : chip select, active low
//   temp_raw     : last received word (signed)
//   temp_avg     : last block average (signed, floor division)
//   sample_cnt   : completed conversions, wraps
//   data_valid   : one-cycle pulse when temp_raw updates
//   avg_valid    : one-cycle pulse when temp_avg updates
//   alarm        : sticky over-temperature flag
//   busy         : high while spi_cs_n is low
module temp_spi_sampler
    import temp_sampler_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 5,
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned AVG_LOG2      = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              enable,
    input  logic [WORD_W-1:0] threshold,
    input  logic              alarm_clr,
    input  logic              spi_miso,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic [WORD_W-1:0] temp_raw,
    output logic [WORD_W-1:0] temp_avg,
    output logic [15:0]       sample_cnt,
    output logic              data_valid,
    output logic              avg_valid,
    output logic              alarm,
    output logic              busy
);

    localparam int unsigned ACC_W = acc_width(AVG_LOG2);
    localparam int unsigned PER_W = $clog2(SAMPLE_PERIOD);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BLK_W = AVG_LOG2 + 1;

    state_t                   state;
    logic [PER_W-1:0]         per_cnt;
    logic [DIV_W-1:0]         phase_cnt;
    logic [BLK_W-1:0]         blk_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     phase_end;
    logic                     blk_end;
    logic                     rx_start;
    logic                     rx_done;
    logic [WORD_W-1:0]        rx_word;

    assign phase_end  = (phase_cnt == DIV_W'(CLK_DIV - 1));
    assign blk_end    = (blk_cnt == BLK_W'((1 << AVG_LOG2) - 1));
    assign rx_start   = (state == S_CS_SETUP) && phase_end;
    assign sample_ext = ACC_W'($signed(rx_word));
    assign acc_sum    = acc + sample_ext;

    temp_spi_rx #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk      (ACLK),
        .rst      (ARESET),
        .start    (rx_start),
        .spi_miso (spi_miso),
        .spi_sclk (spi_sclk),
        .done     (rx_done),
        .word     (rx_word)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= S_IDLE;
            per_cnt    <= '0;
            phase_cnt  <= '0;
            spi_cs_n   <= 1'b1;
            busy       <= 1'b0;
            temp_raw   <= '0;
            temp_avg   <= '0;
            sample_cnt <= '0;
            data_valid <= 1'b0;
            avg_valid  <= 1'b0;
            acc        <= '0;
            blk_cnt    <= '0;
        end else begin
            data_valid <= 1'b0;
            avg_valid  <= 1'b0;
            per_cnt    <= per_cnt + 1'b1;
            phase_cnt  <= phase_cnt + 1'b1;

            case (state)
                S_IDLE: begin
                    per_cnt <= '0;
                    if (enable) begin
                        state     <= S_CS_SETUP;
                        phase_cnt <= '0;
                        spi_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        state   <= S_IDLE;
                        per_cnt <= '0;
                    end else if (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
                        // Period is measured between CS_SETUP entries.
                        state     <= S_CS_SETUP;
                        per_cnt   <= '0;
                        phase_cnt <= '0;
                        spi_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_CS_SETUP: begin
                    if (phase_end) begin
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (rx_done) begin
                        state     <= S_CS_HOLD;
                        phase_cnt <= '0;
                    end
                end
                S_CS_HOLD: begin
                    if (phase_end) begin
                        state    <= S_UPDATE;
                        spi_cs_n <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                S_UPDATE: begin
                    temp_raw   <= rx_word;
                    data_valid <= 1'b1;
                    sample_cnt <= sample_cnt + 1'b1;
                    if (blk_end) begin
                        temp_avg  <= WORD_W'(acc_sum >>> AVG_LOG2);
                        avg_valid <= 1'b1;
                        acc       <= '0;
                        blk_cnt   <= '0;
                    end else begin
                        acc     <= acc_sum;
                        blk_cnt <= blk_cnt + 1'b1;
                    end
                    state <= enable ? S_WAIT : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Compares the freshly registered average, so alarm trails avg_valid by one.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            alarm <= 1'b0;
        end else if (avg_valid && ($signed(temp_avg) > $signed(threshold))) begin
            alarm <= 1'b1;
        end else if (alarm_clr) begin
            alarm <= 1'b0;
        end
    end

endmodule

// File: tb/tb_temp_spi_sampler.sv
module tb_temp_spi_sampler;

    localparam int CLK_DIV = 5;
    localparam int PERIOD  = 200;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] threshold = '0;
    logic        alarm_clr = 1'b0;
    logic        spi_miso = 1'b0;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic [15:0] temp_raw;
    logic [15:0] temp_avg;
    logic [15:0] sample_cnt;
    logic        data_valid;
    logic        avg_valid;
    logic        alarm;
    logic        busy;

    temp_spi_sampler #(
        .CLK_DIV       (CLK_DIV),
        .SAMPLE_PERIOD (PERIOD),
        .AVG_LOG2      (2)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .enable     (enable),
        .threshold  (threshold),
        .alarm_clr  (alarm_clr),
        .spi_miso   (spi_miso),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .temp_raw   (temp_raw),
        .temp_avg   (temp_avg),
        .sample_cnt (sample_cnt),
        .data_valid (data_valid),
        .avg_valid  (avg_valid),
        .alarm      (alarm),
        .busy       (busy)
    );

    always #5 ACLK = ~ACLK;

    // Mode-0 sensor: MSB on CS fall, next bit after each SCLK fall.
    logic [15:0] sensor_q[$];
    logic [15:0] cur_word = 16'hA5A5;
    int          bit_idx = 15;
    logic        cs_last = 1'b1;
    logic        sclk_last = 1'b0;

    always @(spi_cs_n, spi_sclk) begin
        if (cs_last === 1'b1 && spi_cs_n === 1'b0) begin
            if (sensor_q.size() > 0) cur_word = sensor_q.pop_front();
            bit_idx  = 15;
            spi_miso = cur_word[15];
        end else if (sclk_last === 1'b1 && spi_sclk === 1'b0 && spi_cs_n === 1'b0 && bit_idx > 0) begin
            bit_idx  = bit_idx - 1;
            spi_miso = cur_word[bit_idx];
        end
        cs_last   = spi_cs_n;
        sclk_last = spi_sclk;
    end

    // Event monitor, sampled on the inactive clock edge.
    int   cyc = 0, falls = 0, last_fall = 0, dv_cnt = 0, last_dv = 0;
    int   av_cnt = 0, low_cyc = 0, rises = 0;
    logic cs_p = 1'b1, sclk_p = 1'b0;

    always @(negedge ACLK) begin
        cyc <= cyc + 1;
        if (cs_p === 1'b1 && spi_cs_n === 1'b0) begin
            falls     <= falls + 1;
            last_fall <= cyc + 1;
        end
        if (spi_cs_n === 1'b0) low_cyc <= low_cyc + 1;
        if (sclk_p === 1'b0 && spi_sclk === 1'b1) rises <= rises + 1;
        if (data_valid === 1'b1) begin
            dv_cnt  <= dv_cnt + 1;
            last_dv <= cyc + 1;
        end
        if (avg_valid === 1'b1) av_cnt <= av_cnt + 1;
        cs_p   <= spi_cs_n;
        sclk_p <= spi_sclk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
        #1;
    endtask

    task automatic wait_dv(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (data_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rises(input int base, input int n);
        for (int i = 0; i < 400; i++) begin
            if (rises - base >= n) break;
            tick();
        end
    endtask

    typedef struct {
        logic [15:0] s[4];
        logic [15:0] thr;
        logic [15:0] avg;
        logic        alm;
    } blk_t;

    function automatic blk_t mk(input logic [15:0] a, b, c, d, thr, avg, input logic alm);
        blk_t r;
        r.s[0] = a; r.s[1] = b; r.s[2] = c; r.s[3] = d;
        r.thr = thr; r.avg = avg; r.alm = alm;
        return r;
    endfunction

    blk_t tbl[6];

    initial begin
        bit ok;
        int k, r0, l0, d0, f0, prev_fall;

        tbl[0] = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0200, 16'h0280, 1'b1);
        tbl[1] = mk(16'hFF00, 16'hFF00, 16'hFF00, 16'hFEFF, 16'h0000, 16'hFEFF, 1'b0);
        tbl[2] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFE, 16'h7FFF, 1'b1);
        tbl[3] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0);
        tbl[4] = mk(16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'h0000, 1'b1);
        tbl[5] = mk(16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0);

        // Reset values
        repeat (3) tick();
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_raw", temp_raw, 0);
        check("rst_avg", temp_avg, 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_dv", data_valid, 0);
        check("rst_av", avg_valid, 0);
        check("rst_alarm", alarm, 0);
        check("rst_busy", busy, 0);
        ARESET = 1'b0;
        repeat (2) tick();

        // Reset mid-SHIFT: CS and SCLK return to idle at once, word discarded
        r0 = rises;
        enable = 1'b1;
        wait_rises(r0, 3);
        check("midrst_busy_before", busy, 1);
        ARESET = 1'b1;
        #1;
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_sclk", spi_sclk, 0);
        check("midrst_busy", busy, 0);
        enable = 1'b0;
        repeat (2) tick();
        ARESET = 1'b0;
        repeat (400) tick();
        check("midrst_no_dv", dv_cnt, 0);
        check("midrst_raw", temp_raw, 0);

        // Single frame, enable dropped mid-SHIFT
        r0 = rises; l0 = low_cyc; d0 = dv_cnt; f0 = falls;
        sensor_q.push_back(16'h0C80);
        k = cyc;
        enable = 1'b1;
        tick();
        check("en_response", last_fall, k + 1);
        wait_rises(r0, 2);
        enable = 1'b0;
        wait_dv(400, ok);
        check("single_dv_seen", ok, 1);
        check("dv_latency", last_dv - last_fall, 34 * CLK_DIV + 1);
        check("single_raw", temp_raw, 16'h0C80);
        check("single_cnt", sample_cnt, 1);
        check("single_rises", rises - r0, 16);
        check("single_cs_low", low_cyc - l0, 34 * CLK_DIV);
        repeat (2 * PERIOD) tick();
        check("single_dv_once", dv_cnt - d0, 1);
        check("single_one_fall", falls - f0, 1);
        check("single_idle_busy", busy, 0);
        check("single_idle_cs", spi_cs_n, 1);

        // Block averaging and alarm table
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        tick();
        check("rst2_cnt", sample_cnt, 0);
        for (int r = 0; r < 6; r++)
            for (int j = 0; j < 4; j++) sensor_q.push_back(tbl[r].s[j]);
        for (int j = 0; j < 4; j++) sensor_q.push_back(tbl[0].s[j]);
        prev_fall = 0;
        threshold = tbl[0].thr;
        enable = 1'b1;
        for (int r = 0; r < 6; r++) begin
            threshold = tbl[r].thr;
            for (int j = 0; j < 4; j++) begin
                wait_dv(260, ok);
                check("tbl_dv_seen", ok, 1);
                check("tbl_raw", temp_raw, tbl[r].s[j]);
                check("tbl_cnt", sample_cnt, r * 4 + j + 1);
                if (r == 0 && j == 1) check("period", last_fall - prev_fall, PERIOD);
                prev_fall = last_fall;
                if (j == 3) begin
                    check("tbl_avg_valid", avg_valid, 1);
                    check("tbl_avg", temp_avg, tbl[r].avg);
                end else begin
                    check("tbl_no_avg_valid", avg_valid, 0);
                end
            end
            tick();
            check("tbl_alarm", alarm, tbl[r].alm);
            alarm_clr = 1'b1;
            tick();
            alarm_clr = 1'b0;
            check("tbl_alarm_clr", alarm, 0);
        end
        check("tbl_av_count", av_cnt, 6);

        // Set and clear in the same cycle: set wins; a later clear drops it
        threshold = 16'h0200;
        for (int j = 0; j < 4; j++) begin
            wait_dv(260, ok);
            check("sw_dv_seen", ok, 1);
            check("sw_raw", temp_raw, tbl[0].s[j]);
        end
        check("sw_avg_valid", avg_valid, 1);
        check("sw_avg", temp_avg, 16'h0280);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check("set_wins", alarm, 1);
        repeat (5) tick();
        check("alarm_sticky", alarm, 1);
        alarm_clr = 1'b1;
        tick();
        alarm_clr = 1'b0;
        check("late_clr", alarm, 0);
        check("sw_cnt", sample_cnt, 28);

        enable = 1'b0;
        repeat (2 * PERIOD) tick();
        check("final_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
